// File: rtl/pll_sup_pkg.sv
// Shared state encoding and elaboration helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PLL_RST,
    STABILIZE,
    HOLD,
    RUN
  } pll_sup_state_e;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; output lags input by STAGES edges.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the 100 MHz system reset from the asynchronous rPLL LOCK and pulses PLL RESET on lock timeout.
// Define PLL_SUP_RELOCK_CNT_EN to build the saturating relock counter output relock_cnt_o.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int PLL_RST_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock_i,
  input  logic             soft_rst_req_i,
  input  logic             clr_lost_i,
  output logic             pll_reset_o,
  output logic             sys_rst_n_o,
  output logic             ready_o,
  output logic             lock_lost_o
`ifdef PLL_SUP_RELOCK_CNT_EN
  ,
  output logic [CNT_W-1:0] relock_cnt_o
`endif
);

  localparam int TMR_W = clog2(max2(max2(STABLE_CYCLES, HOLD_CYCLES),
                                    max2(LOCK_TIMEOUT, PLL_RST_CYCLES)));

  localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PRST_LAST   = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("pll_lock_supervisor: SYNC_STAGES must be at least 2");
  end
  if ((STABLE_CYCLES < 1) || (HOLD_CYCLES < 1) || (LOCK_TIMEOUT < 1) ||
      (PLL_RST_CYCLES < 1) || (CNT_W < 1)) begin : g_bad_counts
    $error("pll_lock_supervisor: cycle counts and CNT_W must be at least 1");
  end

  logic           lock_s;
  pll_sup_state_e state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic           lost_set;
  logic           lock_lost_q, lock_lost_d;
  logic           sys_rst_n_q, ready_q, pll_reset_q;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TMR_W'(1);
    lost_set = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
        end else if (timer_q == WAIT_LAST) begin
          state_d = PLL_RST;
        end
      end
      PLL_RST: begin
        if (timer_q == PRST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Timer is idle here so it never wraps during long runs.
        timer_d = '0;
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          lost_set = 1'b1;
        end else if (soft_rst_req_i) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
    end
    lock_lost_d = lost_set | (lock_lost_q & ~clr_lost_i);
  end

  // Outputs are registered from next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      timer_q     <= '0;
      lock_lost_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      pll_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lock_lost_q <= lock_lost_d;
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      pll_reset_q <= (state_d == PLL_RST);
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;

`ifdef PLL_SUP_RELOCK_CNT_EN
  logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

  always_comb begin
    relock_cnt_d = relock_cnt_q;
    if (lost_set && (relock_cnt_q != {CNT_W{1'b1}})) begin
      relock_cnt_d = relock_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      relock_cnt_q <= '0;
    end else begin
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign relock_cnt_o = relock_cnt_q;
`endif

endmodule
